// File: rtl/pp_source_arbiter.sv
// pp_source_arbiter: shares the PreProcessing pipeline between two camera sources.
// Round-robin arbitration picks a source, its image is latched, and a 4-phase
// Req/Ack handshake runs downstream. The acknowledge goes back only to the granted
// source, and a frame counter is kept for each source.
//
// Handshake rules, upstream and downstream: a requester raises Req and holds it and
// its data stable until Ack rises. It then drops Req, and Ack falls after that. No new
// Req is accepted until Ack has returned to 0.
module pp_source_arbiter #(
  parameter  int IMAGE_BITS = 8,
  parameter  int MATRIX_N   = 120,
  parameter  int MATRIX_M   = 120,
  parameter  int CNT_BITS   = 16,
  localparam int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [FLAT_WIDE-1:0] ImgMatIn0,
  input  logic                 ReqIn0,
  output logic                 AckIn0,
  input  logic [FLAT_WIDE-1:0] ImgMatIn1,
  input  logic                 ReqIn1,
  output logic                 AckIn1,
  output logic                 ReqOut,
  input  logic                 AckOut,
  output logic [FLAT_WIDE-1:0] ImgMatOut,
  output logic                 Grant,
  output logic                 Busy,
  output logic [CNT_BITS-1:0]  FrameCnt0,
  output logic [CNT_BITS-1:0]  FrameCnt1,
  output logic [1:0]           StateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t state, stateNext;

  // The round-robin priority bit. A 0 here favours source 0.
  logic pri, priNext;

  logic                 ackIn0Next, ackIn1Next, reqOutNext, grantNext, busyNext;
  logic [FLAT_WIDE-1:0] imgNext;
  logic [CNT_BITS-1:0]  cnt0Next, cnt1Next;

  logic anyReq, winner, grantedReq;

  // If only one source requests, it wins. If both request, the priority bit decides.
  assign anyReq     = ReqIn0 | ReqIn1;
  assign winner     = (ReqIn0 & ReqIn1) ? pri : ReqIn1;
  assign grantedReq = Grant ? ReqIn1 : ReqIn0;
  assign StateDbg   = state;

  // State and registered outputs. Reset abandons any transfer in progress.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      pri       <= 1'b0;
      AckIn0    <= 1'b0;
      AckIn1    <= 1'b0;
      ReqOut    <= 1'b0;
      ImgMatOut <= '0;
      Grant     <= 1'b0;
      Busy      <= 1'b0;
      FrameCnt0 <= '0;
      FrameCnt1 <= '0;
    end else begin
      state     <= stateNext;
      pri       <= priNext;
      AckIn0    <= ackIn0Next;
      AckIn1    <= ackIn1Next;
      ReqOut    <= reqOutNext;
      ImgMatOut <= imgNext;
      Grant     <= grantNext;
      Busy      <= busyNext;
      FrameCnt0 <= cnt0Next;
      FrameCnt1 <= cnt1Next;
    end
  end

  // Next-state logic. A new grant can only happen from IDLE, so there is always at
  // least one idle cycle between two transfers.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (anyReq)      stateNext = REQ;
      REQ:  if (AckOut)      stateNext = REL;
      REL:  if (!AckOut)     stateNext = ACK;
      ACK:  if (!grantedReq) stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  // Next values for the registered outputs. Every output holds its value unless the
  // current state's transition changes it.
  always_comb begin
    priNext    = pri;
    ackIn0Next = AckIn0;
    ackIn1Next = AckIn1;
    reqOutNext = ReqOut;
    imgNext    = ImgMatOut;
    grantNext  = Grant;
    busyNext   = Busy;
    cnt0Next   = FrameCnt0;
    cnt1Next   = FrameCnt1;
    unique case (state)
      IDLE: begin
        if (anyReq) begin
          grantNext  = winner;
          imgNext    = winner ? ImgMatIn1 : ImgMatIn0;
          reqOutNext = 1'b1;
          busyNext   = 1'b1;
        end
      end
      REQ: begin
        if (AckOut) reqOutNext = 1'b0;
      end
      REL: begin
        if (!AckOut) begin
          ackIn0Next = ~Grant;
          ackIn1Next = Grant;
        end
      end
      ACK: begin
        if (!grantedReq) begin
          ackIn0Next = 1'b0;
          ackIn1Next = 1'b0;
          if (Grant) cnt1Next = FrameCnt1 + CNT_BITS'(1);
          else       cnt0Next = FrameCnt0 + CNT_BITS'(1);
          priNext    = ~Grant;
          busyNext   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pp_source_arbiter.sv
// Bench for pp_source_arbiter. It uses a small image and a 2-bit counter so that
// counter wrap-around can be reached quickly.
module tb_pp_source_arbiter;

  localparam int IB = 8;
  localparam int MN = 4;
  localparam int MM = 4;
  localparam int CB = 2;
  localparam int FW = IB * MN * MM;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [FW-1:0] ImgMatIn0, ImgMatIn1, ImgMatOut;
  logic          ReqIn0, ReqIn1, AckIn0, AckIn1, ReqOut, AckOut, Grant, Busy;
  logic [CB-1:0] FrameCnt0, FrameCnt1;
  logic [1:0]    StateDbg;

  int checks   = 0;
  int failures = 0;

  // Each entry holds {expected Grant, expected ImgMatOut} for one transfer.
  logic [FW:0] exp_q[$];
  int          model_cnt[2];
  logic        model_pri;

  pp_source_arbiter #(
    .IMAGE_BITS(IB), .MATRIX_N(MN), .MATRIX_M(MM), .CNT_BITS(CB)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .ImgMatIn0(ImgMatIn0), .ReqIn0(ReqIn0), .AckIn0(AckIn0),
    .ImgMatIn1(ImgMatIn1), .ReqIn1(ReqIn1), .AckIn1(AckIn1),
    .ReqOut(ReqOut), .AckOut(AckOut), .ImgMatOut(ImgMatOut),
    .Grant(Grant), .Busy(Busy),
    .FrameCnt0(FrameCnt0), .FrameCnt1(FrameCnt1), .StateDbg(StateDbg)
  );

  // Clock generation and a watchdog so the run always terminates.
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_img();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Wait at negedges, for up to a bounded number of cycles, until the chosen signal
  // reaches val. Signal selector: 0 ReqOut, 1 AckIn0, 2 AckIn1, 3 Busy.
  task automatic wait_sig(input int which, input logic val, input int budget,
                          input string tag, output int n);
    logic s;
    n = 0;
    s = ~val;
    while (n < budget) begin
      @(negedge Clk);
      n++;
      case (which)
        0:       s = ReqOut;
        1:       s = AckIn0;
        2:       s = AckIn1;
        default: s = Busy;
      endcase
      if (s === val) break;
    end
    check({tag, "_reached"}, s === val, 1'b1);
  endtask

  // Work out which source should win the next grant from the request levels the bench
  // is driving, and push the expected result onto the scoreboard.
  task automatic expect_next();
    logic w;
    w = (ReqIn0 && ReqIn1) ? model_pri : ReqIn1;
    exp_q.push_back({w, w ? ImgMatIn1 : ImgMatIn0});
  endtask

  // Carry one transfer from ReqOut rising through to the completion of the ack.
  task automatic serve(input int ackDelay, input bit reraise, input logic [FW-1:0] newImg,
                       output int lat, output logic g);
    logic [FW:0] exp;
    int          n;
    bit          ok;
    wait_sig(0, 1'b1, 20, "req_out_rise", lat);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", exp_q.size(), 1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    g = exp[FW];
    check("grant", Grant, exp[FW]);
    check("img_out", ImgMatOut, exp[FW-1:0]);
    check("ack_low_in_req", {AckIn0, AckIn1}, 2'b00);
    check("busy_in_req", Busy, 1'b1);
    // Disturb the granted source's input. The latched image must not change.
    if (g) ImgMatIn1 = ~ImgMatIn1;
    else   ImgMatIn0 = ~ImgMatIn0;
    repeat (2) @(negedge Clk);
    check("img_hold", ImgMatOut, exp[FW-1:0]);
    ok = 1'b1;
    for (int i = 0; i < ackDelay; i++) begin
      @(negedge Clk);
      if (!(ReqOut === 1'b1 && Busy === 1'b1 && AckIn0 === 1'b0 && AckIn1 === 1'b0)) ok = 1'b0;
    end
    if (ackDelay > 0) check("slow_hold", ok, 1'b1);
    AckOut = 1'b1;
    wait_sig(0, 1'b0, 10, "req_out_fall", n);
    AckOut = 1'b0;
    wait_sig(g ? 2 : 1, 1'b1, 10, "ack_in_rise", n);
    check("other_ack_low", g ? AckIn0 : AckIn1, 1'b0);
    check("req_out_low_in_ack", ReqOut, 1'b0);
    if (g) ReqIn1 = 1'b0;
    else   ReqIn0 = 1'b0;
    wait_sig(g ? 2 : 1, 1'b0, 10, "ack_in_fall", n);
    model_cnt[g]++;
    model_pri = ~g;
    check("frame_cnt0", FrameCnt0, model_cnt[0] % (1 << CB));
    check("frame_cnt1", FrameCnt1, model_cnt[1] % (1 << CB));
    check("busy_done", Busy, 1'b0);
    if (reraise) begin
      if (g) begin ImgMatIn1 = newImg; ReqIn1 = 1'b1; end
      else   begin ImgMatIn0 = newImg; ReqIn0 = 1'b1; end
    end
  endtask

  initial begin
    int   lat, n;
    logic g;
    Reset = 1'b0; ReqIn0 = 1'b0; ReqIn1 = 1'b0; AckOut = 1'b0;
    ImgMatIn0 = '0; ImgMatIn1 = '0;
    model_pri = 1'b0; model_cnt[0] = 0; model_cnt[1] = 0;

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset_outputs", {ReqOut, AckIn0, AckIn1, Grant, Busy, FrameCnt0, FrameCnt1, ImgMatOut}, '0);
    check("reset_state", StateDbg, 2'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Single source 0 transfer, checking the one-cycle request latency
    ImgMatIn0 = rand_img(); ReqIn0 = 1'b1;
    expect_next();
    serve(0, 1'b0, '0, lat, g);
    check("req_latency", lat, 1);

    // Five source-1 transfers make the 2-bit counter wrap: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      ImgMatIn1 = rand_img(); ReqIn1 = 1'b1;
      expect_next();
      serve(0, 1'b0, '0, lat, g);
    end

    // Reset asserted in the middle of REQ
    ImgMatIn0 = rand_img(); ReqIn0 = 1'b1;
    wait_sig(0, 1'b1, 20, "mid_req_rise", n);
    check("mid_req_state", StateDbg, 2'd1);
    Reset = 1'b0;
    #1;
    check("mid_reset_outputs", {ReqOut, AckIn0, AckIn1, Grant, Busy, FrameCnt0, FrameCnt1, ImgMatOut}, '0);
    ReqIn0 = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    model_cnt[0] = 0; model_cnt[1] = 0; model_pri = 1'b0;
    @(negedge Clk);
    check("post_reset_state", StateDbg, 2'd0);
    check("post_reset_busy", {Busy, ReqOut}, 2'b00);

    // Contention: both sources request. Each of the first two winners re-requests at once.
    ImgMatIn0 = rand_img(); ImgMatIn1 = rand_img();
    ReqIn0 = 1'b1; ReqIn1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_next();
      serve(0, i < 2, rand_img(), lat, g);
      check("contention_grant_seq", g, i % 2);
    end
    check("contention_cnt0", FrameCnt0, 2'd2);
    check("contention_cnt1", FrameCnt1, 2'd2);

    // Slow downstream: the ack is held off for 50 cycles
    ImgMatIn0 = rand_img(); ReqIn0 = 1'b1;
    expect_next();
    serve(50, 1'b0, '0, lat, g);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
